ofifo_col_buffer: RTL
=====================

Name: ofifo_col_buffer

Overview:
- Output collection buffer directly downstream of the south edge of the mac_tile systolic array.
- Each array column drives one psum word plus a per-column write strobe whenever that column produces a result.
  - In WS mode this is the bottom tile's out_s.
  - In OS mode this is the drained os_out_tile value.
- Columns finish at skewed times, so each column has an independent FIFO.
- A full row (one word per column) is presented to the SFP/memory write-back stage only when every column holds at least one entry; one rd pops a whole row.

Parameters:
- col, 8, number of array columns / independent column FIFOs.
- psum_bw, 16, width of one psum word.
- depth, 64, entries per column FIFO; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in  input  col*psum_bw  column words; column i occupies bits [i*psum_bw +: psum_bw].
- wr  input  col  per-column write strobe; wr[i] pushes column i's word.
- rd  input  1  pop one full row from all columns.
- out  output  col*psum_bw  head-of-FIFO row, show-ahead; same bit packing as in.
- o_valid  output  1  every column FIFO non-empty.
- o_full  output  1  at least one column FIFO full.
- o_ready  output  1  no column FIFO full (equals ~o_full).
- o_ovf  output  1  sticky: a write was dropped because its column was full.
- o_udf  output  1  sticky: rd was asserted while o_valid was low.

Behaviour:
- Reset (synchronous, active-high):
  - All read and write pointers are cleared to 0 and all FIFOs become empty.
  - o_ovf=0, o_udf=0, o_valid=0, o_full=0, o_ready=1, out=0.
  - Storage contents are not cleared and are don't-care.
  - Reset wins over any simultaneous wr/rd. Reset mid-operation discards all buffered data; the first post-reset write to a column lands at entry 0.
- Pointers:
  - Each column has a log2(depth)+1-bit write pointer and read pointer. The extra MSB distinguishes full from empty.
  - empty_i = (wptr_i == rptr_i).
  - full_i = (low bits equal) and (MSB differs).
  - Pointers wrap naturally modulo 2*depth, so there is no special wrap handling.
- Write:
  - On posedge, if wr[i] and the column accepts the write, in[i] is stored at wptr_i and wptr_i increments.
  - Column i accepts the write if ~full_i, or if full_i and a row pop is accepted in the same cycle.
  - If wr[i] arrives while full_i and no pop is accepted, the word is dropped, wptr_i holds, and o_ovf sets.
  - Columns are fully independent; any subset of wr bits may be high.
- Read:
  - A pop is accepted when rd and o_valid. It increments every rptr_i in the same cycle.
  - rd with o_valid=0 changes no pointer and sets o_udf.
- Output:
  - out is combinational from storage at rptr_i: out = o_valid ? head row : 0.
  - Zero latency from o_valid to data; the row popped by rd is the row visible on out during that cycle.
- Simultaneous read and write on the same column, both accepted: occupancy of that column is unchanged.
  - Data written to an empty column becomes visible on the next cycle, never the same cycle; there is no write-to-read bypass.
- Latency:
  - wr at edge N: the column counts as non-empty from edge N onward.
  - o_valid rises in the cycle after the last missing column is written.
- o_valid, o_full and o_ready are combinational from pointers, i.e. registered-state-derived with no input-to-output path.
- Per-column occupancy never exceeds depth. Sticky flags clear only on reset.

Test Plan:
- Reset, then idle: o_valid=0, o_ready=1, out=0, flags 0. Then rd=1 for one cycle -> o_udf=1, pointers unchanged; a subsequent row write still reads back correctly.
- Skewed fill (col=8): write column i at cycle i with value 16'h0100+i -> o_valid rises only in the cycle after column 7's write; out = {16'h0107,...,16'h0100}. rd one cycle -> o_valid=0, out=0.
- Fill all columns with depth=4 rows 1..4 (column i, row r value = r*16+i) -> o_full=1, o_ready=0. A 5th write on column 3 only -> o_ovf=1. Drain with 4 rds -> rows appear in order 1..4 and the 5th value never appears.
- Simultaneous rd and wr on all columns at full (depth=4) -> pop of row 1 and push of row 5 both accepted, o_full stays 1, o_ovf stays 0. Draining yields 2,3,4,5.
- Wrap-around: push/pop 3*depth+1 rows, one row in flight at a time, data = row index -> every row reads back exactly, o_ovf=o_udf=0.
- Reset asserted mid-fill (2 rows in, o_valid=1) -> next cycle o_valid=0, out=0. A new row 16'hABCD on all columns reads back as the first row.

Source files
------------

// File: rtl/ofifo_col_buffer_if.sv
// rtl/ofifo_col_buffer_if.sv - column-write / row-read bundle for the output collection buffer
interface ofifo_col_buffer_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16
);
    logic [col*psum_bw-1:0] in;
    logic [col-1:0]         wr;
    logic                   rd;
    logic [col*psum_bw-1:0] out;
    logic                   o_valid;
    logic                   o_full;
    logic                   o_ready;
    logic                   o_ovf;
    logic                   o_udf;

    modport master (
        output in, wr, rd,
        input  out, o_valid, o_full, o_ready, o_ovf, o_udf
    );

    modport slave (
        input  in, wr, rd,
        output out, o_valid, o_full, o_ready, o_ovf, o_udf
    );
endinterface

// File: rtl/ofifo_col_buffer.sv
// rtl/ofifo_col_buffer.sv - per-column psum FIFOs presenting aligned rows to write-back
module ofifo_col_buffer #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic               clk,
    input  logic               reset,
    ofifo_col_buffer_if.slave  bus
);
    localparam int aw = $clog2(depth);

    logic [psum_bw-1:0] mem  [col][depth];
    logic [aw:0]        wptr [col];
    logic [aw:0]        rptr [col];

    logic [col-1:0] empty;
    logic [col-1:0] full;
    logic [col-1:0] accept;
    logic           valid;
    logic           pop;

    // Extra pointer MSB separates a full column from an empty one.
    always_comb begin
        empty = '0;
        full  = '0;
        for (int i = 0; i < col; i++) begin
            empty[i] = (wptr[i] == rptr[i]);
            full[i]  = (wptr[i][aw-1:0] == rptr[i][aw-1:0]) && (wptr[i][aw] != rptr[i][aw]);
        end
    end

    assign valid  = ~|empty;
    assign pop    = bus.rd & valid;
    // A full column may still take a word when the row pop frees a slot this cycle.
    assign accept = bus.wr & (~full | {col{pop}});

    assign bus.o_valid = valid;
    assign bus.o_full  = |full;
    assign bus.o_ready = ~|full;

    always_comb begin
        bus.out = '0;
        if (valid) begin
            for (int i = 0; i < col; i++) begin
                bus.out[i*psum_bw +: psum_bw] = mem[i][rptr[i][aw-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (accept[i]) begin
                mem[i][wptr[i][aw-1:0]] <= bus.in[i*psum_bw +: psum_bw];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < col; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
            end
            bus.o_ovf <= 1'b0;
            bus.o_udf <= 1'b0;
        end else begin
            for (int i = 0; i < col; i++) begin
                if (accept[i]) wptr[i] <= wptr[i] + 1'b1;
                if (pop)       rptr[i] <= rptr[i] + 1'b1;
            end
            if (|(bus.wr & full & ~{col{pop}})) bus.o_ovf <= 1'b1;
            if (bus.rd && !valid)               bus.o_udf <= 1'b1;
        end
    end
endmodule
